// File: rtl/mem_to_fifo_ctrl.sv
// mem_to_fifo_ctrl: copies NUM_WORDS ROM words starting at BASE_ADDR into a
// downstream FIFO. Define MEM_TO_FIFO_LOOP_EN to stream passes until restart.
module mem_to_fifo_ctrl #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                NUM_WORDS = 4
) (
    input  logic              clk_mem,
    input  logic              reset,
    input  logic              start,
    input  logic              restart,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              fifo_full,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_re,
    output logic              rom_ce,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
);

    localparam int CW = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                rom_re_q;
    logic                rom_ce_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                busy_q;
    logic                done_q;
    logic [CW-1:0]       cnt_q;

    logic                wr_ok_d;
    logic                last_d;
    logic [ADDR_W-1:0]   idx_d;
    logic [ADDR_W-1:0]   next_addr_d;
    logic [CW-1:0]       cnt_d;

    // Write handshake plus the index/address/count of the following word.
    always_comb begin
        wr_ok_d     = (state_q == S_WRITE) && !fifo_full && !restart;
        last_d      = (idx_q == LAST_IDX);
        idx_d       = last_d ? '0 : idx_q + IDX_ONE;
        next_addr_d = BASE_ADDR + idx_d;
        cnt_d       = cnt_q + CNT_ONE;
    end

    // Transfer sequencer; every output except fifo_wr is registered here.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rom_addr_q <= '0;
            rom_re_q   <= 1'b0;
            rom_ce_q   <= 1'b0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rom_re_q <= 1'b0;
`ifdef MEM_TO_FIFO_LOOP_EN
            done_q   <= 1'b0;
`endif
            if (restart) begin
                state_q  <= S_IDLE;
                idx_q    <= '0;
                cnt_q    <= '0;
                rom_ce_q <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state_q    <= S_READ;
                            idx_q      <= '0;
                            cnt_q      <= '0;
                            rom_addr_q <= BASE_ADDR;
                            rom_re_q   <= 1'b1;
                            rom_ce_q   <= 1'b1;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                        end
                    end
                    S_READ: begin
                        state_q <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        wdata_q <= rom_data;
                        state_q <= S_WRITE;
                    end
                    S_WRITE: begin
                        if (wr_ok_d) begin
                            state_q    <= S_READ;
                            idx_q      <= idx_d;
                            cnt_q      <= cnt_d;
                            rom_addr_q <= next_addr_d;
                            rom_re_q   <= 1'b1;
                            if (last_d) begin
`ifdef MEM_TO_FIFO_LOOP_EN
                                cnt_q    <= '0;
                                done_q   <= 1'b1;
`else
                                state_q  <= S_DONE;
                                rom_re_q <= 1'b0;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
`endif
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rom_re     = rom_re_q;
    assign rom_ce     = rom_ce_q;
    assign fifo_wr    = wr_ok_d;
    assign fifo_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_mem_to_fifo_ctrl.sv
// tb_mem_to_fifo_ctrl: randomized checks of mem_to_fifo_ctrl against a
// word-stream model (ROM image, FIFO contents queue, address log).
module tb_mem_to_fifo_ctrl;

    localparam int         NW   = 4;
    localparam logic [3:0] BASE = 4'd14;
`ifdef MEM_TO_FIFO_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk_mem = 1'b0;
    logic       reset;
    logic       start;
    logic       restart;
    logic [7:0] rom_data;
    logic       fifo_full;
    logic [3:0] rom_addr;
    logic       rom_re;
    logic       rom_ce;
    logic       fifo_wr;
    logic [7:0] fifo_wdata;
    logic       busy;
    logic       done;
    logic [4:0] word_count;

    int vecs = 0;
    int errs = 0;

    logic [7:0] rom [16];
    logic [7:0] obs_q[$];
    logic [3:0] addr_q[$];
    int         full_wr = 0;

    mem_to_fifo_ctrl #(
        .DATA_W   (8),
        .ADDR_W   (4),
        .BASE_ADDR(BASE),
        .NUM_WORDS(NW)
    ) dut (
        .clk_mem   (clk_mem),
        .reset     (reset),
        .start     (start),
        .restart   (restart),
        .rom_data  (rom_data),
        .fifo_full (fifo_full),
        .rom_addr  (rom_addr),
        .rom_re    (rom_re),
        .rom_ce    (rom_ce),
        .fifo_wr   (fifo_wr),
        .fifo_wdata(fifo_wdata),
        .busy      (busy),
        .done      (done),
        .word_count(word_count)
    );

    always #5 clk_mem = ~clk_mem;

    // Synchronous ROM: data appears one cycle after the read enable.
    always @(posedge clk_mem) begin
        if (rom_re) rom_data <= rom[rom_addr];
    end

    // FIFO model and read-address log.
    always @(posedge clk_mem) begin
        if (fifo_wr) begin
            obs_q.push_back(fifo_wdata);
            if (fifo_full) full_wr++;
        end
        if (rom_re) addr_q.push_back(rom_addr);
    end

    function automatic logic [3:0] exp_addr(int i);
        return 4'((int'(BASE) + (i % NW)) % 16);
    endfunction

    function automatic logic [7:0] exp_word(int i);
        return rom[exp_addr(i)];
    endfunction

    task automatic tick();
        @(posedge clk_mem);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        restart = 1'b0;
        fifo_full = 1'b0;
        tick();
        reset = 1'b0;
        obs_q.delete();
        addr_q.delete();
        full_wr = 0;
    endtask

    task automatic fill_rom_random();
        for (int a = 0; a < 16; a++) rom[a] = 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        restart = 1'b0;
        fifo_full = 1'b0;
        @(negedge clk_mem);
        vecs++;
        if ({rom_addr, rom_re, rom_ce, fifo_wr, busy, done} !== 9'd0) begin
            errs++;
            $display("FAIL reset_ctrl got %b want 0",
                     {rom_addr, rom_re, rom_ce, fifo_wr, busy, done});
        end
        vecs++;
        if (fifo_wdata !== 8'h00) begin
            errs++;
            $display("FAIL reset_wdata got %h want 00", fifo_wdata);
        end
        vecs++;
        if (word_count !== 5'd0) begin
            errs++;
            $display("FAIL reset_count got %0d want 0", word_count);
        end
        start = 1'b1;
        tick();
        @(negedge clk_mem);
        vecs++;
        if (busy !== 1'b0 || rom_re !== 1'b0) begin
            errs++;
            $display("FAIL reset_start busy=%b re=%b want 0", busy, rom_re);
        end
        start = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_pass();
        logic       e_wr, e_re, e_busy, e_done;
        int         e_wc;
        logic [7:0] e_dat;
        for (int a = 0; a < 16; a++)
            rom[a] = 8'hA0 + 8'((a - int'(BASE)) & 15);
        do_reset();
        for (int k = 0; k < 16; k++) begin
            start = (k == 0);
            fifo_full = 1'b0;
            @(negedge clk_mem);
            e_wr   = (k > 0) && (k % 3 == 0) && (LOOP || k <= 12);
            e_re   = (k % 3 == 1) && (LOOP || k <= 10);
            e_busy = (k >= 1) && (LOOP || k <= 12);
            e_done = LOOP ? (k == 13) : (k >= 13);
            e_wc   = (k == 0) ? 0 : ((k - 1) / 3) % (LOOP ? NW : NW + 1);
            vecs++;
            if ({fifo_wr, rom_re, rom_ce, busy, done} !==
                {e_wr, e_re, (k >= 1), e_busy, e_done}) begin
                errs++;
                $display("FAIL pass_ctrl c%0d got %b want %b", k,
                         {fifo_wr, rom_re, rom_ce, busy, done},
                         {e_wr, e_re, (k >= 1), e_busy, e_done});
            end
            vecs++;
            if (word_count !== 5'(e_wc)) begin
                errs++;
                $display("FAIL pass_count c%0d got %0d want %0d",
                         k, word_count, e_wc);
            end
            if (e_re) begin
                vecs++;
                if (rom_addr !== exp_addr((k - 1) / 3)) begin
                    errs++;
                    $display("FAIL pass_addr c%0d got %0d want %0d", k,
                             rom_addr, exp_addr((k - 1) / 3));
                end
            end
            if (e_wr) begin
                e_dat = 8'hA0 + 8'((k / 3 - 1) % NW);
                vecs++;
                if (fifo_wdata !== e_dat) begin
                    errs++;
                    $display("FAIL pass_data c%0d got %h want %h",
                             k, fifo_wdata, e_dat);
                end
            end
            tick();
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_backpressure();
        fill_rom_random();
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            start = (k == 0);
            fifo_full = (k >= 3 && k <= 7);
            @(negedge clk_mem);
            if (k >= 3) begin
                vecs++;
                if (fifo_wr !== (k == 8)) begin
                    errs++;
                    $display("FAIL bp_wr c%0d got %b want %b",
                             k, fifo_wr, (k == 8));
                end
                vecs++;
                if (fifo_wdata !== exp_word(0)) begin
                    errs++;
                    $display("FAIL bp_hold c%0d got %h want %h",
                             k, fifo_wdata, exp_word(0));
                end
            end
            tick();
        end
        start = 1'b0;
        for (int c = 0; c < 200 && obs_q.size() < NW; c++) begin
            fifo_full = ($urandom_range(0, 2) == 0);
            @(negedge clk_mem);
            vecs++;
            if (fifo_full && fifo_wr !== 1'b0) begin
                errs++;
                $display("FAIL bp_full_wr got wr=%b want 0", fifo_wr);
            end
            tick();
        end
        vecs++;
        if (obs_q.size() != NW) begin
            errs++;
            $display("FAIL bp_writes got %0d want %0d", obs_q.size(), NW);
        end
        fifo_full = 1'b0;
        @(negedge clk_mem);
        vecs++;
        if (done !== 1'b1) begin
            errs++;
            $display("FAIL bp_done got %b want 1", done);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_word(i)) begin
                errs++;
                $display("FAIL bp_data w%0d got %h want %h",
                         i, obs_q[i], exp_word(i));
            end
        end
        vecs++;
        if (full_wr != 0) begin
            errs++;
            $display("FAIL bp_wr_when_full got %0d want 0", full_wr);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_addr_wrap();
        fill_rom_random();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200 && obs_q.size() < NW; c++) begin
            fifo_full = ($urandom_range(0, 3) == 0);
            tick();
        end
        fifo_full = 1'b0;
        vecs++;
        if (addr_q.size() < NW) begin
            errs++;
            $display("FAIL wrap_reads got %0d want %0d", addr_q.size(), NW);
        end
        for (int i = 0; i < NW && i < addr_q.size(); i++) begin
            vecs++;
            if (addr_q[i] !== exp_addr(i)) begin
                errs++;
                $display("FAIL wrap_addr r%0d got %0d want %0d",
                         i, addr_q[i], exp_addr(i));
            end
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int e_wc;
        fill_rom_random();
        do_reset();
        start = 1'b1;
        tick();
        for (int c = 0; c < 300 && obs_q.size() < NW; c++) begin
            start = $urandom_range(0, 1);
            fifo_full = ($urandom_range(0, 2) == 0);
            @(negedge clk_mem);
            e_wc = obs_q.size() % (LOOP ? NW : NW + 1);
            vecs++;
            if (word_count !== 5'(e_wc) || busy !== 1'b1) begin
                errs++;
                $display("FAIL busy_state got cnt=%0d busy=%b want %0d 1",
                         word_count, busy, e_wc);
            end
            tick();
        end
        start = 1'b0;
        fifo_full = 1'b0;
        vecs++;
        if (obs_q.size() != NW || addr_q.size() != NW) begin
            errs++;
            $display("FAIL busy_len got w=%0d r=%0d want %0d",
                     obs_q.size(), addr_q.size(), NW);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_word(i)) begin
                errs++;
                $display("FAIL busy_data w%0d got %h want %h",
                         i, obs_q[i], exp_word(i));
            end
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_restart();
        fill_rom_random();
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            start = (k == 0);
            restart = (k == 8);
            @(negedge clk_mem);
            tick();
        end
        restart = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_mem);
            vecs++;
            if ({busy, rom_ce, done, fifo_wr} !== 4'b0 ||
                word_count !== 5'd0) begin
                errs++;
                $display("FAIL rst_idle c%0d got %b cnt=%0d want 0", c,
                         {busy, rom_ce, done, fifo_wr}, word_count);
            end
            tick();
        end
        vecs++;
        if (obs_q.size() != 2) begin
            errs++;
            $display("FAIL rst_cap_writes got %0d want 2", obs_q.size());
        end
        obs_q.delete();
        addr_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        restart = 1'b1;
        @(negedge clk_mem);
        vecs++;
        if (fifo_wr !== 1'b0) begin
            errs++;
            $display("FAIL rst_wr_cycle got %b want 0", fifo_wr);
        end
        tick();
        restart = 1'b0;
        @(negedge clk_mem);
        vecs++;
        if (obs_q.size() != 0 || busy !== 1'b0 || word_count !== 5'd0) begin
            errs++;
            $display("FAIL rst_write got w=%0d busy=%b cnt=%0d want 0",
                     obs_q.size(), busy, word_count);
        end
        start = 1'b1;
        restart = 1'b1;
        tick();
        start = 1'b0;
        restart = 1'b0;
        @(negedge clk_mem);
        vecs++;
        if (busy !== 1'b0 || rom_re !== 1'b0) begin
            errs++;
            $display("FAIL rst_prio got busy=%b re=%b want 0", busy, rom_re);
        end
        tick();
        obs_q.delete();
        addr_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200 && obs_q.size() < NW; c++) begin
            fifo_full = ($urandom_range(0, 2) == 0);
            tick();
        end
        fifo_full = 1'b0;
        vecs++;
        if (obs_q.size() != NW || addr_q.size() == 0) begin
            errs++;
            $display("FAIL rst_rerun got %0d want %0d", obs_q.size(), NW);
        end else begin
            vecs++;
            if (addr_q[0] !== exp_addr(0)) begin
                errs++;
                $display("FAIL rst_base got %0d want %0d",
                         addr_q[0], exp_addr(0));
            end
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_word(i)) begin
                errs++;
                $display("FAIL rst_data w%0d got %h want %h",
                         i, obs_q[i], exp_word(i));
            end
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        fill_rom_random();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        @(negedge clk_mem);
        vecs++;
        if (fifo_wr !== 1'b1) begin
            errs++;
            $display("FAIL mid_pre_wr got %b want 1", fifo_wr);
        end
        #2;
        reset = 1'b1;
        #1;
        vecs++;
        if ({rom_addr, rom_re, rom_ce, fifo_wr, busy, done,
             word_count, fifo_wdata} !== 27'd0) begin
            errs++;
            $display("FAIL mid_async got %h want 0",
                     {rom_addr, rom_re, rom_ce, fifo_wr, busy, done,
                      word_count, fifo_wdata});
        end
        tick();
        vecs++;
        if (obs_q.size() != 0) begin
            errs++;
            $display("FAIL mid_glitch got %0d writes want 0", obs_q.size());
        end
        reset = 1'b0;
    endtask

`ifdef MEM_TO_FIFO_LOOP_EN
    task automatic test_loop();
        int   prev;
        int   pulses;
        logic e_done;
        fill_rom_random();
        do_reset();
        prev = 0;
        pulses = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 600 && obs_q.size() < 3 * NW; c++) begin
            fifo_full = ($urandom_range(0, 2) == 0);
            @(negedge clk_mem);
            e_done = (obs_q.size() != prev) && (obs_q.size() % NW == 0);
            vecs++;
            if (done !== e_done) begin
                errs++;
                $display("FAIL loop_done w%0d got %b want %b",
                         obs_q.size(), done, e_done);
            end
            if (done === 1'b1) pulses++;
            prev = obs_q.size();
            tick();
        end
        fifo_full = 1'b0;
        @(negedge clk_mem);
        vecs++;
        if (done !== 1'b1 || pulses != 2) begin
            errs++;
            $display("FAIL loop_pulses got %b/%0d want 1/2", done, pulses);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_word(i)) begin
                errs++;
                $display("FAIL loop_data w%0d got %h want %h",
                         i, obs_q[i], exp_word(i));
            end
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        prev = obs_q.size();
        repeat (10) tick();
        vecs++;
        if (obs_q.size() != prev || busy !== 1'b0) begin
            errs++;
            $display("FAIL loop_stop got %0d busy=%b want %0d 0",
                     obs_q.size(), busy, prev);
        end
    endtask
`else
    task automatic test_done_hold();
        fill_rom_random();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 100 && obs_q.size() < NW; c++) tick();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_mem);
            vecs++;
            if ({done, busy, rom_ce, fifo_wr} !== 4'b1010 ||
                word_count !== 5'(NW)) begin
                errs++;
                $display("FAIL done_hold c%0d got %b cnt=%0d want 1010 %0d",
                         c, {done, busy, rom_ce, fifo_wr}, word_count, NW);
            end
            tick();
        end
        obs_q.delete();
        addr_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk_mem);
        vecs++;
        if ({done, busy, rom_re} !== 3'b011 || rom_addr !== exp_addr(0)) begin
            errs++;
            $display("FAIL done_restart got %b a=%0d want 011 a=%0d",
                     {done, busy, rom_re}, rom_addr, exp_addr(0));
        end
        for (int c = 0; c < 200 && obs_q.size() < NW; c++) begin
            fifo_full = ($urandom_range(0, 2) == 0);
            tick();
        end
        fifo_full = 1'b0;
        vecs++;
        if (obs_q.size() != NW) begin
            errs++;
            $display("FAIL done_rerun got %0d want %0d", obs_q.size(), NW);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            vecs++;
            if (obs_q[i] !== exp_word(i)) begin
                errs++;
                $display("FAIL done_data w%0d got %h want %h",
                         i, obs_q[i], exp_word(i));
            end
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        rom_data = 8'h00;
        test_reset();
        test_single_pass();
        test_backpressure();
        test_addr_wrap();
        test_start_while_busy();
        test_restart();
        test_reset_mid_write();
`ifdef MEM_TO_FIFO_LOOP_EN
        test_loop();
`else
        test_done_hold();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_to_fifo_ctrl.md
Name: mem_to_fifo_ctrl

Overview:
Parametrised ROM-to-FIFO transfer engine; successor to the fixed 4-word ROM loader.
- Reads NUM_WORDS consecutive ROM words from BASE_ADDR and writes each into a downstream FIFO.
- Honours FIFO backpressure, supports software start/restart and reports progress.
- Sits between the on-chip ROM and the clock-domain-crossing FIFO, entirely in the clk_mem domain.

Parameters:
DATA_W, 8, ROM/FIFO data width
ADDR_W, 4, ROM address width
BASE_ADDR, 0, first ROM address read (ADDR_W bits)
NUM_WORDS, 4, words per pass; legal range 1..2**ADDR_W

Ports:
clk_mem  in  1  clock; everything rising-edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a pass; sampled only in IDLE or DONE
restart  in  1  synchronous abort to IDLE; priority over start
rom_data  in  DATA_W  ROM read data, valid 1 cycle after rom_re
fifo_full  in  1  FIFO full flag
rom_addr  out  ADDR_W  ROM address
rom_re  out  1  ROM read enable
rom_ce  out  1  ROM chip enable, high in any non-IDLE state
fifo_wr  out  1  FIFO write strobe
fifo_wdata  out  DATA_W  FIFO write data (registered)
busy  out  1  high in READ/CAPTURE/WRITE
done  out  1  high while in DONE
word_count  out  ADDR_W+1  words written this pass

Behaviour:
Reset (async, reset=1): state=IDLE; rom_addr, fifo_wdata, word_count = 0; rom_re, rom_ce, fifo_wr, busy, done = 0.

States:
- IDLE: start=1 -> READ; index=0, word_count=0.
- READ: rom_addr=BASE_ADDR+index (mod 2**ADDR_W), rom_re=1 -> CAPTURE.
- CAPTURE: fifo_wdata<=rom_data -> WRITE.
- WRITE: fifo_wr = ~fifo_full (combinational from state and fifo_full).
  - fifo_full=1: remain in WRITE; fifo_wdata held; no write.
  - Write accepted: word_count+1. If this was word NUM_WORDS-1 -> DONE, else index+1 -> READ.
- DONE: done=1, word_count held. start=1 -> READ with index=0, word_count=0.

Rules:
- rom_re asserted only in READ. rom_addr is registered and holds its value outside READ.
- Exactly one fifo_wr per word; never a write while fifo_full=1.
- Throughput with no backpressure: 3 cycles per word.
- start while busy: ignored.
- restart in any state: next state IDLE, word_count=0, no fifo_wr in that cycle; an in-flight word is dropped.
- restart and start in the same cycle: restart wins; block stays in IDLE.
- Address wrap: BASE_ADDR+index above 2**ADDR_W-1 wraps modulo 2**ADDR_W.
- reset mid-pass: immediate return to reset values, no glitch write.

Optional Feature:
Macro: MEM_TO_FIFO_LOOP_EN
- Defined: the accepted write of the last word goes to READ with index=0 and word_count=0. The block streams continuously until restart. done pulses for 1 cycle per completed pass; DONE state is unused.
- Undefined: single pass, then DONE as above.

Test Plan:
1. Reset, then 1-cycle start at cycle 0; ROM[i]=8'hA0+i; fifo_full=0, NUM_WORDS=4 -> fifo_wr high at cycles 3,6,9,12 with data A0,A1,A2,A3; done=1 from cycle 13; word_count=4.
2. fifo_full=1 for 5 cycles when first entering WRITE -> fifo_wr stays 0 and fifo_wdata holds A0; write occurs on the first cycle fifo_full=0; total writes still 4, no duplicates.
3. BASE_ADDR=14, NUM_WORDS=4, ADDR_W=4 -> rom_addr sequence 14,15,0,1.
4. restart asserted in the CAPTURE state of word 2 -> IDLE next cycle, word_count=0, no further fifo_wr; a new start then rereads from BASE_ADDR.
5. reset pulsed mid-WRITE with fifo_full=0 -> all outputs 0 asynchronously, no write on that edge; start while busy has no effect.
6. With MEM_TO_FIFO_LOOP_EN defined, NUM_WORDS=2 -> data A0,A1,A0,A1... repeats; done pulses after each A1 write; restart stops the stream.
